// File: rtl/e191_drv_pkg.sv
// Shared definitions for the e191 stimulus driver: state codes, sequencer
// states and the controller edge table (x stimulus / expected y per edge).
package e191_drv_pkg;

    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;
    localparam logic [3:0] S11 = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } drv_state_t;

    typedef struct packed {
        logic        legal;
        logic [15:0] x;
        logic [10:0] y;
    } edge_t;

    // x bit i-1 = xi, y bit i-1 = yi; anything not listed is not a direct edge
    function automatic edge_t edge_lookup(input logic [3:0] src, input logic [3:0] dst);
        edge_t ent;
        case ({src, dst})
            {S1, S2}:   ent = '{1'b1, 16'h8180, 11'h200};
            {S1, S3}:   ent = '{1'b1, 16'h8100, 11'h008};
            {S1, S4}:   ent = '{1'b1, 16'h0100, 11'h010};
            {S1, S5}:   ent = '{1'b1, 16'h0210, 11'h001};
            {S1, S6}:   ent = '{1'b1, 16'h0001, 11'h001};
            {S1, S7}:   ent = '{1'b1, 16'h0002, 11'h004};
            {S1, S8}:   ent = '{1'b1, 16'h0000, 11'h002};
            {S2, S9}:   ent = '{1'b1, 16'h0000, 11'h080};
            {S3, S7}:   ent = '{1'b1, 16'h01C0, 11'h004};
            {S3, S3}:   ent = '{1'b1, 16'h0140, 11'h000};
            {S3, S1}:   ent = '{1'b1, 16'h0040, 11'h000};
            {S3, S10}:  ent = '{1'b1, 16'h1028, 11'h401};
            {S4, S6}:   ent = '{1'b1, 16'h0001, 11'h001};
            {S4, S7}:   ent = '{1'b1, 16'h0002, 11'h004};
            {S4, S8}:   ent = '{1'b1, 16'h0000, 11'h002};
            {S5, S11}:  ent = '{1'b1, 16'h4800, 11'h020};
            {S5, S5}:   ent = '{1'b1, 16'h0800, 11'h000};
            {S5, S1}:   ent = '{1'b1, 16'h0004, 11'h000};
            {S5, S3}:   ent = '{1'b1, 16'h0000, 11'h008};
            {S6, S7}:   ent = '{1'b1, 16'h0002, 11'h004};
            {S6, S8}:   ent = '{1'b1, 16'h0000, 11'h002};
            {S7, S2}:   ent = '{1'b1, 16'hA010, 11'h040};
            {S7, S3}:   ent = '{1'b1, 16'hA000, 11'h008};
            {S7, S5}:   ent = '{1'b1, 16'h0410, 11'h001};
            {S7, S1}:   ent = '{1'b1, 16'h0004, 11'h000};
            {S8, S5}:   ent = '{1'b1, 16'h0400, 11'h001};
            {S8, S1}:   ent = '{1'b1, 16'h0004, 11'h000};
            {S8, S3}:   ent = '{1'b1, 16'h0000, 11'h008};
            {S9, S1}:   ent = '{1'b1, 16'h0008, 11'h100};
            {S9, S9}:   ent = '{1'b1, 16'h0000, 11'h000};
            {S10, S11}: ent = '{1'b1, 16'h4000, 11'h020};
            {S10, S10}: ent = '{1'b1, 16'h0000, 11'h000};
            {S11, S2}:  ent = '{1'b1, 16'h0000, 11'h200};
            default:    ent = '{1'b0, 16'h0000, 11'h000};
        endcase
        return ent;
    endfunction

endpackage

// File: rtl/e191_drv_fifo.sv
// Synchronous FIFO holding queued target-state codes; combinational head read.
module e191_drv_fifo
#(
    parameter int DEPTH = 8,
    parameter int W     = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;

    // Pointer/storage update; the extra pointer bit tells full from empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/e191_stim_driver.sv
// e191 stimulus driver: steers the controller one edge per queued target and checks y.
// Optional TROJAN_WATCH_EN adds trojan_flag (s4-run followed by s6/s7/s8 mismatch).
module e191_stim_driver
    import e191_drv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ERR_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [3:0]       tgt_state,
    output logic             tgt_ready,
    output logic [15:0]      x_out,
    input  logic [10:0]      y_obs,
    output logic             busy,
    output logic             nack,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cur_state
`ifdef TROJAN_WATCH_EN
    ,
    output logic             trojan_flag
`endif
);

    drv_state_t       state_r;
    logic [3:0]       cur_state_r;
    logic [3:0]       tgt_r;
    logic [15:0]      x_r;
    logic [10:0]      exp_y_r;
    logic             nack_r;
    logic             err_r;
    logic [ERR_W-1:0] err_cnt_r;

    logic       push_s;
    logic       pop_s;
    logic [3:0] head_s;
    logic       full_s;
    logic       empty_s;
    edge_t      lookup_s;

    // A full queue still accepts when the sequencer is about to pop its head
    assign tgt_ready = !full_s || (state_r == IDLE);
    assign push_s    = tgt_valid && tgt_ready;
    assign pop_s     = (state_r == IDLE) && !empty_s;

    e191_drv_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (tgt_state),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Edge lookup from the believed state to the queue head
    always_comb begin
        lookup_s = edge_lookup(cur_state_r, head_s);
    end

    // Sequencer: pop a target, drive its edge vector, then check the returned word
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cur_state_r <= S1;
            tgt_r       <= 4'd0;
            x_r         <= 16'h0000;
            exp_y_r     <= 11'h000;
            nack_r      <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            nack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        tgt_r <= head_s;
                        if (lookup_s.legal) begin
                            x_r     <= lookup_s.x;
                            exp_y_r <= lookup_s.y;
                            state_r <= DRIVE;
                        end else begin
                            x_r    <= 16'h0000;
                            nack_r <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    state_r <= CHECK;
                end
                CHECK: begin
                    // Belief follows the target regardless of y; divergence is counted, not repaired
                    if (y_obs != exp_y_r) begin
                        err_r <= 1'b1;
                        if (err_cnt_r != '1) begin
                            err_cnt_r <= err_cnt_r + ERR_W'(1);
                        end
                    end
                    cur_state_r <= tgt_r;
                    x_r         <= 16'h0000;
                    state_r     <= IDLE;
                end
                default: begin
                    x_r     <= 16'h0000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign x_out     = x_r;
    assign busy      = (state_r != IDLE) || !empty_s;
    assign nack      = nack_r;
    assign err       = err_r;
    assign err_count = err_cnt_r;
    assign cur_state = cur_state_r;

`ifdef TROJAN_WATCH_EN
    logic [3:0] src4_cnt_r;
    logic [3:0] prev_src_r;
    logic       trojan_r;

    // Watch for a run of s4-sourced edges followed by a mismatch out of s6/s7/s8
    always_ff @(posedge clk) begin
        if (!rst) begin
            src4_cnt_r <= 4'd0;
            prev_src_r <= 4'd0;
            trojan_r   <= 1'b0;
        end else if (state_r == CHECK) begin
            if ((y_obs != exp_y_r) && (prev_src_r == S4) && (src4_cnt_r >= 4'd5) &&
                ((cur_state_r == S6) || (cur_state_r == S7) || (cur_state_r == S8))) begin
                trojan_r <= 1'b1;
            end
            if ((cur_state_r == S4) && (src4_cnt_r != 4'hF)) begin
                src4_cnt_r <= src4_cnt_r + 4'd1;
            end
            prev_src_r <= cur_state_r;
        end
    end

    assign trojan_flag = trojan_r;
`endif

endmodule

// File: tb/tb_e191_stim_driver.sv
// Bench for e191_stim_driver: directed vector table, hand sequences and random
// traffic, all checked against a queue-based reference model of the edge rules.
module tb_e191_stim_driver;
    localparam int DEPTH = 8;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tgt_valid = 1'b0;
    logic [3:0]       tgt_state = 4'd0;
    logic [10:0]      y_obs = 11'h000;
    logic             tgt_ready;
    logic [15:0]      x_out;
    logic             busy;
    logic             nack;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       cur_state;
`ifdef TROJAN_WATCH_EN
    logic             trojan_flag;
`endif

    e191_stim_driver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_state (tgt_state),
        .tgt_ready (tgt_ready),
        .x_out     (x_out),
        .y_obs     (y_obs),
        .busy      (busy),
        .nack      (nack),
        .err       (err),
        .err_count (err_count),
        .cur_state (cur_state)
`ifdef TROJAN_WATCH_EN
        ,
        .trojan_flag (trojan_flag)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Edge table written as lists of x / y indices
    bit          leg [16][16];
    logic [15:0] ex  [16][16];
    logic [10:0] ey  [16][16];

    function automatic logic [15:0] xb(input int i);
        logic [15:0] v;
        v = 16'h0000;
        if (i > 0) v[i-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [10:0] yb(input int i);
        logic [10:0] v;
        v = 11'h000;
        if (i > 0) v[i-1] = 1'b1;
        return v;
    endfunction

    task automatic add_edge(input int s, input int d, input int x1, input int x2, input int x3,
                            input int y1, input int y2);
        leg[s][d] = 1'b1;
        ex[s][d]  = xb(x1) | xb(x2) | xb(x3);
        ey[s][d]  = yb(y1) | yb(y2);
    endtask

    // Reference model: queue of targets, belief state, cycles left in the current edge
    int          q[$];
    int          m_cur = 1;
    int          m_left = 0;
    int          m_tgt = 0;
    logic [15:0] m_x = 16'h0000;
    logic [10:0] m_y = 11'h000;
    bit          m_nack = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    bit          chk_en = 1'b0;
    int          ymode = 0;

    always @(posedge clk) begin : model_b
        bit acc;
        if (!rst) begin
            q.delete();
            m_cur = 1; m_left = 0; m_x = 16'h0000; m_y = 11'h000;
            m_nack = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            acc = tgt_valid && ((q.size() < DEPTH) || (m_left == 0));
            m_nack = 1'b0;
            if (m_left == 0 && q.size() > 0) begin
                m_tgt = q.pop_front();
                if (leg[m_cur][m_tgt]) begin
                    m_x = ex[m_cur][m_tgt];
                    m_y = ey[m_cur][m_tgt];
                    m_left = 2;
                end else begin
                    m_x = 16'h0000;
                    m_nack = 1'b1;
                end
            end else if (m_left == 2) begin
                m_left = 1;
            end else if (m_left == 1) begin
                if (y_obs !== m_y) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                m_cur = m_tgt;
                m_x = 16'h0000;
                m_left = 0;
            end
            if (acc) q.push_back(int'(tgt_state));
        end
    end

    // Controller stand-in: echo, zero, random-ish or inverted y word
    always @(negedge clk) begin
        case (ymode)
            0: y_obs = m_y;
            1: y_obs = 11'h000;
            2: y_obs = ($urandom_range(0, 1) == 1) ? m_y : 11'($urandom);
            3: y_obs = ~m_y;
            default: y_obs = m_y;
        endcase
    end

    // Cycle-by-cycle comparison with the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_x_out", x_out, m_x);
            chk("m_nack", nack, m_nack);
            chk("m_err", err, m_err);
            chk("m_err_count", err_count, 32'(m_cnt));
            chk("m_cur_state", cur_state, 32'(m_cur));
            chk("m_busy", busy, (m_left != 0) || (q.size() > 0));
            chk("m_tgt_ready", tgt_ready, (q.size() < DEPTH) || (m_left == 0));
        end
    end

    typedef struct packed {
        logic [3:0]  tgt;
        logic [1:0]  ym;
        logic [15:0] x;
        logic        nk;
        logic [3:0]  cur;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tv [11];

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic run1(input logic [3:0] t);
        @(negedge clk); tgt_valid = 1'b1; tgt_state = t;
        @(negedge clk); tgt_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] xs;
        bit nks, seen_nr, done;
        int k, nk_n, last, tail, d;
        int succ[$];

        add_edge(1, 2, 9, 16, 8, 10, 0);  add_edge(1, 3, 9, 16, 0, 4, 0);
        add_edge(1, 4, 9, 0, 0, 5, 0);    add_edge(1, 5, 10, 5, 0, 1, 0);
        add_edge(1, 6, 1, 0, 0, 1, 0);    add_edge(1, 7, 2, 0, 0, 3, 0);
        add_edge(1, 8, 0, 0, 0, 2, 0);    add_edge(2, 9, 0, 0, 0, 8, 0);
        add_edge(3, 7, 7, 9, 8, 3, 0);    add_edge(3, 3, 7, 9, 0, 0, 0);
        add_edge(3, 1, 7, 0, 0, 0, 0);    add_edge(3, 10, 6, 4, 13, 1, 11);
        add_edge(4, 6, 1, 0, 0, 1, 0);    add_edge(4, 7, 2, 0, 0, 3, 0);
        add_edge(4, 8, 0, 0, 0, 2, 0);    add_edge(5, 11, 12, 15, 0, 6, 0);
        add_edge(5, 5, 12, 0, 0, 0, 0);   add_edge(5, 1, 3, 0, 0, 0, 0);
        add_edge(5, 3, 0, 0, 0, 4, 0);    add_edge(6, 7, 2, 0, 0, 3, 0);
        add_edge(6, 8, 0, 0, 0, 2, 0);    add_edge(7, 2, 16, 14, 5, 7, 0);
        add_edge(7, 3, 16, 14, 0, 4, 0);  add_edge(7, 5, 11, 5, 0, 1, 0);
        add_edge(7, 1, 3, 0, 0, 0, 0);    add_edge(8, 5, 11, 0, 0, 1, 0);
        add_edge(8, 1, 3, 0, 0, 0, 0);    add_edge(8, 3, 0, 0, 0, 4, 0);
        add_edge(9, 1, 4, 0, 0, 9, 0);    add_edge(9, 9, 0, 0, 0, 0, 0);
        add_edge(10, 11, 15, 0, 0, 6, 0); add_edge(10, 10, 0, 0, 0, 0, 0);
        add_edge(11, 2, 0, 0, 0, 10, 0);

        //          tgt    ymode  x         nack  cur    err_count
        tv[0]  = '{4'd4,  2'd0, 16'h0100, 1'b0, 4'd4, 8'd0};
        tv[1]  = '{4'd6,  2'd0, 16'h0001, 1'b0, 4'd6, 8'd0};
        tv[2]  = '{4'd7,  2'd0, 16'h0002, 1'b0, 4'd7, 8'd0};
        tv[3]  = '{4'd2,  2'd0, 16'hA010, 1'b0, 4'd2, 8'd0};
        tv[4]  = '{4'd9,  2'd0, 16'h0000, 1'b0, 4'd9, 8'd0};
        tv[5]  = '{4'd1,  2'd0, 16'h0008, 1'b0, 4'd1, 8'd0};
        tv[6]  = '{4'd9,  2'd0, 16'h0000, 1'b1, 4'd1, 8'd0};
        tv[7]  = '{4'd13, 2'd0, 16'h0000, 1'b1, 4'd1, 8'd0};
        tv[8]  = '{4'd2,  2'd1, 16'h8180, 1'b0, 4'd2, 8'd1};
        tv[9]  = '{4'd9,  2'd1, 16'h0000, 1'b0, 4'd9, 8'd2};
        tv[10] = '{4'd1,  2'd0, 16'h0008, 1'b0, 4'd1, 8'd2};

        // Reset values
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_x_out", x_out, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tgt_ready", tgt_ready, 1'b1);
        chk("rst_cur_state", cur_state, 4'd1);
        chk("rst_err", err, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_nack", nack, 1'b0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            ymode = int'(tv[i].ym);
            @(negedge clk); tgt_valid = 1'b1; tgt_state = tv[i].tgt;
            xs = 16'h0000; nks = 1'b0;
            repeat (6) begin
                @(negedge clk); tgt_valid = 1'b0;
                xs |= x_out; nks |= nack;
            end
            chk($sformatf("v%0d_x", i), xs, tv[i].x);
            chk($sformatf("v%0d_nack", i), nks, tv[i].nk);
            chk($sformatf("v%0d_cur", i), cur_state, tv[i].cur);
            chk($sformatf("v%0d_errcnt", i), err_count, tv[i].cnt);
            chk($sformatf("v%0d_idle", i), busy, 1'b0);
        end
        ymode = 0;

        // Reset while driving 1->3
        @(negedge clk); tgt_valid = 1'b1; tgt_state = 4'd3;
        @(negedge clk); tgt_valid = 1'b0;
        @(negedge clk);
        chk("drv_x_out", x_out, 16'h8100);
        rst = 1'b0;
        @(negedge clk);
        chk("rstdrv_x_out", x_out, 16'h0000);
        chk("rstdrv_busy", busy, 1'b0);
        chk("rstdrv_cur", cur_state, 4'd1);
        chk("rstdrv_err", err, 1'b0);
        rst = 1'b1;

        // Fill the queue with alternating 3/7 and drain it in order
        k = 0; seen_nr = 1'b0; nk_n = 0; done = 1'b0;
        repeat (24) begin
            @(negedge clk);
            tgt_valid = 1'b1;
            tgt_state = (k % 2 == 0) ? 4'd3 : 4'd7;
            if (tgt_ready) k++;
            else seen_nr = 1'b1;
        end
        last = (k % 2 == 1) ? 3 : 7;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk); tgt_valid = 1'b0;
            if (nack) nk_n++;
            if (!busy) done = 1'b1;
        end
        chk("fullq_seen_not_ready", seen_nr, 1'b1);
        chk("fullq_drained", done, 1'b1);
        chk("fullq_no_nack", nk_n, 0);
        chk("fullq_cur", cur_state, last);

        // Random traffic, mostly along legal edges
        ymode = 2;
        tail = m_cur;
        repeat (400) begin
            @(negedge clk);
            tgt_valid = ($urandom_range(0, 2) != 0);
            succ.delete();
            for (int s = 0; s < 16; s++) if (leg[tail][s]) succ.push_back(s);
            if ($urandom_range(0, 4) != 0 && succ.size() > 0)
                d = succ[$urandom_range(0, succ.size() - 1)];
            else
                d = $urandom_range(0, 15);
            tgt_state = 4'(d);
            if (tgt_valid && tgt_ready && leg[tail][d]) tail = d;
        end
        @(negedge clk); tgt_valid = 1'b0;
        repeat (40) @(negedge clk);

        // Error counter saturation: every check mismatches
        do_reset();
        ymode = 3;
        repeat (900) begin
            @(negedge clk); tgt_valid = 1'b1; tgt_state = 4'd3;
        end
        @(negedge clk); tgt_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("sat_err_count", err_count, 8'hFF);
        chk("sat_err", err, 1'b1);
        ymode = 0;

`ifdef TROJAN_WATCH_EN
        do_reset();
        for (int l = 0; l < 5; l++) begin
            run1(4'd4); run1(4'd6); run1(4'd8); run1(4'd1);
        end
        run1(4'd4); run1(4'd6);
        chk("trojan_quiet", trojan_flag, 1'b0);
        ymode = 1;
        run1(4'd7);
        ymode = 0;
        chk("trojan_set", trojan_flag, 1'b1);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
